// File: rtl/comm_pkg.sv
// Shared definitions for the transmit path: serializer state encoding,
// the default sync preamble (also used by the downstream sync detector)
// and the default frame length in sysclk cycles.
package comm_pkg;

  // Serializer states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    DATA   = 2'd2,
    PARITY = 2'd3
  } state_e;

  // Default frame geometry
  localparam int DATA_W_DEFAULT     = 8;
  localparam int SYNC_W_DEFAULT     = 4;
  localparam int BIT_CYCLES_DEFAULT = 1;

  // Sync preamble, sent MSB first; the receiver hunts for this pattern
  localparam logic [SYNC_W_DEFAULT-1:0] SYNC_PAT_DEFAULT = 4'b1010;

  // Frame length in sysclk cycles: sync + data + parity, each bit held BIT_CYCLES
  localparam int FRAME_LEN =
    (SYNC_W_DEFAULT + DATA_W_DEFAULT + 1) * BIT_CYCLES_DEFAULT;

  // Frame length for arbitrary geometry
  function automatic int frame_len(input int sync_w, input int data_w, input int bit_cycles);
    return (sync_w + data_w + 1) * bit_cycles;
  endfunction

endpackage

// File: rtl/frame_bit_timer.sv
// Bit-period timer for the frame serializer. While run is high it counts
// 0..BIT_CYCLES-1 and wraps, pulsing bit_tick in the last cycle of each
// bit period. When run is low the count is held at zero, so the first bit
// of a new frame always gets a full period.
module frame_bit_timer #(
  parameter int BIT_CYCLES = 1
) (
  input  logic sysclk,
  input  logic reset,
  input  logic run,
  output logic bit_tick
);

  // A single-cycle bit period still needs a one-bit counter
  localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  assign bit_tick = run && (cnt == CNT_LAST);

  // Period counter: cleared when idle, wraps at the end of every bit
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (!run || bit_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/frame_serializer.sv
// Frame serializer: on a trans_enable strobe, captures data_in and sends
// sync preamble, payload and parity MSB-first on tx_bit. The first sync bit
// is on the line from the accepting edge, each bit lasts BIT_CYCLES cycles,
// and frame_done pulses once the line has returned to idle. All outputs are
// registered. Strobes that arrive while a frame is in flight are dropped
// and latch the sticky overrun flag.
module frame_serializer
  import comm_pkg::*;
#(
  parameter int                DATA_W     = DATA_W_DEFAULT,
  parameter int                SYNC_W     = SYNC_W_DEFAULT,
  parameter logic [SYNC_W-1:0] SYNC_PAT   = SYNC_PAT_DEFAULT,
  parameter int                BIT_CYCLES = BIT_CYCLES_DEFAULT,
  parameter bit                PARITY_ODD = 1'b0
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              trans_enable,
  input  logic [DATA_W-1:0] data_in,
  output logic              tx_bit,
  output logic              tx_active,
  output logic              frame_done,
  output logic              overrun
);

  // Bit index wide enough for the longer field, never wraps mid-field
  localparam int IDX_W = $clog2((SYNC_W > DATA_W) ? SYNC_W : DATA_W) + 1;
  localparam logic [IDX_W-1:0] SYNC_LAST = IDX_W'(SYNC_W - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_W - 1);

  state_e            state;
  logic [IDX_W-1:0]  bit_idx;
  logic [SYNC_W-1:0] sync_sr;
  logic [DATA_W-1:0] data_sr;
  logic              parity_bit;
  logic              busy;
  logic              bit_tick;

  assign busy = (state != IDLE);

  frame_bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_bit_timer (
    .sysclk   (sysclk),
    .reset    (reset),
    .run      (busy),
    .bit_tick (bit_tick)
  );

  // Sticky overrun: any strobe seen while a frame is in flight
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (trans_enable && busy) begin
      overrun <= 1'b1;
    end
  end

  // Frame sequencer: captures the word, walks sync/data/parity and drives the line
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      bit_idx    <= '0;
      sync_sr    <= '0;
      data_sr    <= '0;
      parity_bit <= 1'b0;
      tx_bit     <= 1'b1;
      tx_active  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (trans_enable) begin
            state      <= SYNC;
            bit_idx    <= '0;
            sync_sr    <= SYNC_PAT << 1;
            data_sr    <= data_in;
            parity_bit <= (^data_in) ^ PARITY_ODD;
            tx_bit     <= SYNC_PAT[SYNC_W-1];
            tx_active  <= 1'b1;
          end
        end
        SYNC: begin
          if (bit_tick) begin
            if (bit_idx == SYNC_LAST) begin
              state   <= DATA;
              bit_idx <= '0;
              tx_bit  <= data_sr[DATA_W-1];
              data_sr <= data_sr << 1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx_bit  <= sync_sr[SYNC_W-1];
              sync_sr <= sync_sr << 1;
            end
          end
        end
        DATA: begin
          if (bit_tick) begin
            if (bit_idx == DATA_LAST) begin
              state   <= PARITY;
              bit_idx <= '0;
              tx_bit  <= parity_bit;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx_bit  <= data_sr[DATA_W-1];
              data_sr <= data_sr << 1;
            end
          end
        end
        PARITY: begin
          if (bit_tick) begin
            state      <= IDLE;
            tx_bit     <= 1'b1;
            tx_active  <= 1'b0;
            frame_done <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_serializer.sv
// Bench for frame_serializer. Three instances share clock and reset:
// default parameters, odd parity, and four cycles per bit. Inputs change
// and outputs are sampled on the falling edge.
module tb_frame_serializer;

  logic       sysclk = 1'b0;
  logic       reset;
  logic       te         [3];
  logic [7:0] din        [3];
  logic       tx_bit_w   [3];
  logic       tx_active_w[3];
  logic       done_w     [3];
  logic       overrun_w  [3];

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    int          inst;
    int          bc;
    logic [7:0]  data;
    logic [12:0] frame;
    string       name;
  } vec_t;

  vec_t vecs[10];

  always #5 sysclk = ~sysclk;

  frame_serializer u_def (
    .sysclk(sysclk), .reset(reset), .trans_enable(te[0]), .data_in(din[0]),
    .tx_bit(tx_bit_w[0]), .tx_active(tx_active_w[0]), .frame_done(done_w[0]),
    .overrun(overrun_w[0])
  );

  frame_serializer #(.PARITY_ODD(1'b1)) u_odd (
    .sysclk(sysclk), .reset(reset), .trans_enable(te[1]), .data_in(din[1]),
    .tx_bit(tx_bit_w[1]), .tx_active(tx_active_w[1]), .frame_done(done_w[1]),
    .overrun(overrun_w[1])
  );

  frame_serializer #(.BIT_CYCLES(4)) u_slow (
    .sysclk(sysclk), .reset(reset), .trans_enable(te[2]), .data_in(din[2]),
    .tx_bit(tx_bit_w[2]), .tx_active(tx_active_w[2]), .frame_done(done_w[2]),
    .overrun(overrun_w[2])
  );

  task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
    total_cnt++;
    if (act !== exp) begin
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  // {tx_bit, tx_active, frame_done, overrun} for instance k
  function automatic logic [7:0] line_state(input int k);
    return {4'b0, tx_bit_w[k], tx_active_w[k], done_w[k], overrun_w[k]};
  endfunction

  // Called at a falling edge: strobe one cycle, then scramble data_in
  task automatic apply_stimulus(input int k, input logic [7:0] d);
    te[k]  = 1'b1;
    din[k] = d;
    @(negedge sysclk);
    te[k]  = 1'b0;
    din[k] = ~d;
  endtask

  // Starts in cycle T; checks every frame cycle and the done cycle T+N.
  // Optionally raises trans_enable during frame cycles inj_a / inj_b.
  task automatic watch_frame(input int k, input logic [12:0] fr, input int bc,
                             input int inj_a, input int inj_b, input string name);
    for (int i = 0; i < 13 * bc; i++) begin
      check_output($sformatf("%s cyc%0d", name, i),
                   {5'b0, tx_bit_w[k], tx_active_w[k], done_w[k]},
                   {5'b0, fr[12 - i / bc], 2'b10});
      te[k] = (i == inj_a) || (i == inj_b);
      if (te[k]) din[k] = 8'($urandom);
      @(negedge sysclk);
    end
    te[k] = 1'b0;
    check_output($sformatf("%s done", name),
                 {5'b0, tx_bit_w[k], tx_active_w[k], done_w[k]}, 8'b101);
  endtask

  initial begin
    // Hand-computed frames: {1010, data, parity}
    vecs[0] = '{0, 1, 8'hA5, 13'b1010_10100101_0, "def_A5"};
    vecs[1] = '{0, 1, 8'h07, 13'b1010_00000111_1, "def_07"};
    vecs[2] = '{0, 1, 8'h00, 13'b1010_00000000_0, "def_00"};
    vecs[3] = '{0, 1, 8'hFF, 13'b1010_11111111_0, "def_FF"};
    vecs[4] = '{0, 1, 8'h3C, 13'b1010_00111100_0, "def_3C"};
    vecs[5] = '{0, 1, 8'h80, 13'b1010_10000000_1, "def_80"};
    vecs[6] = '{1, 1, 8'h07, 13'b1010_00000111_0, "odd_07"};
    vecs[7] = '{1, 1, 8'h00, 13'b1010_00000000_1, "odd_00"};
    vecs[8] = '{2, 4, 8'hFF, 13'b1010_11111111_0, "slow_FF"};
    vecs[9] = '{2, 4, 8'h5A, 13'b1010_01011010_0, "slow_5A"};

    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      te[k]  = 1'b0;
      din[k] = 8'h00;
    end

    // Reset held five cycles, then twenty idle cycles
    repeat (5) begin
      @(negedge sysclk);
      for (int k = 0; k < 3; k++) check_output($sformatf("reset%0d", k), line_state(k), 8'b1000);
    end
    reset = 1'b0;
    repeat (20) begin
      @(negedge sysclk);
      for (int k = 0; k < 3; k++) check_output($sformatf("idle%0d", k), line_state(k), 8'b1000);
    end

    // Table of single frames
    for (int v = 0; v < 10; v++) begin
      @(negedge sysclk);
      apply_stimulus(vecs[v].inst, vecs[v].data);
      watch_frame(vecs[v].inst, vecs[v].frame, vecs[v].bc, -1, -1, vecs[v].name);
      @(negedge sysclk);
      check_output({vecs[v].name, " after"}, line_state(vecs[v].inst), 8'b1000);
    end

    // Strobe in the frame_done cycle is accepted without overrun
    @(negedge sysclk);
    apply_stimulus(0, 8'hA5);
    watch_frame(0, 13'b1010_10100101_0, 1, -1, -1, "chainA");
    apply_stimulus(0, 8'h3C);
    watch_frame(0, 13'b1010_00111100_0, 1, -1, -1, "chainB");
    check_output("chain ovr", {7'b0, overrun_w[0]}, 8'h0);

    // Strobes at T+5 and T+12 are dropped, set overrun; T+13 is accepted
    @(negedge sysclk);
    apply_stimulus(0, 8'hA5);
    watch_frame(0, 13'b1010_10100101_0, 1, 5, 12, "ovrA");
    check_output("ovr set", {7'b0, overrun_w[0]}, 8'h1);
    apply_stimulus(0, 8'h80);
    watch_frame(0, 13'b1010_10000000_1, 1, -1, -1, "ovrB");
    @(negedge sysclk);
    check_output("ovr sticky", line_state(0), 8'b1001);

    // Held strobe on the odd-parity instance: only the first edge counts
    @(negedge sysclk);
    apply_stimulus(1, 8'h07);
    watch_frame(1, 13'b1010_00000111_0, 1, 0, 1, "held");
    @(negedge sysclk);
    check_output("held ovr", line_state(1), 8'b1001);

    // Reset in the middle of a frame abandons it
    @(negedge sysclk);
    apply_stimulus(0, 8'hFF);
    repeat (6) @(negedge sysclk);
    check_output("mid active", {7'b0, tx_active_w[0]}, 8'h1);
    @(posedge sysclk);
    #2 reset = 1'b1;
    #1 check_output("mid reset", line_state(0), 8'b1000);
    for (int k = 1; k < 3; k++) check_output($sformatf("mid reset%0d", k), line_state(k), 8'b1000);
    repeat (2) @(negedge sysclk);
    reset = 1'b0;
    repeat (15) begin
      @(negedge sysclk);
      check_output("post reset idle", line_state(0), 8'b1000);
    end
    apply_stimulus(0, 8'h3C);
    watch_frame(0, 13'b1010_00111100_0, 1, -1, -1, "recover");
    @(negedge sysclk);
    check_output("recover after", line_state(0), 8'b1000);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/frame_serializer.md
Name: frame_serializer

Overview:
- Transmit stage directly downstream of the 256-cycle frame alert generator.
- On each one-cycle `trans_enable` pulse, captures a parallel data word and serialises it MSB-first onto `tx_bit` as: sync pattern, data, parity.
- With default parameters the frame completes inside the 16-cycle window before `test_enable`, so the test stage sees a complete frame on the line.

Parameters:
- DATA_W, 8, payload width in bits.
- SYNC_W, 4, sync preamble width in bits.
- SYNC_PAT, 4'b1010, sync preamble, sent MSB first.
- BIT_CYCLES, 1, sysclk cycles each serial bit is held (>=1).
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity over the data bits.

Ports:
- sysclk  input  1  system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- trans_enable  input  1  one-cycle frame-start strobe from the frame alert generator.
- data_in  input  DATA_W  payload; sampled only on an accepted trans_enable.
- tx_bit  output  1  serial line; idle level 1.
- tx_active  output  1  high while frame bits are on tx_bit.
- frame_done  output  1  one-cycle pulse after the last bit.
- overrun  output  1  sticky flag: a trans_enable arrived while busy.

Behaviour:
- One clock (sysclk); reset is asynchronous and active-high.
- Reset values: tx_bit=1, tx_active=0, frame_done=0, overrun=0, state=IDLE, shift register=0, counters=0.
- States:
  - IDLE -> SYNC on the edge where trans_enable=1.
  - SYNC -> DATA after SYNC_W bits.
  - DATA -> PARITY after DATA_W bits.
  - PARITY -> IDLE after 1 bit.
- Capture: on the accepting edge (call it edge T), data_in is registered and the parity bit is computed. Parity = XOR of data_in, inverted when PARITY_ODD=1.
- Output timing:
  - The first sync bit drives tx_bit from edge T onward.
  - Each bit is held exactly BIT_CYCLES cycles.
  - Frame length N = (SYNC_W+DATA_W+1)*BIT_CYCLES cycles, default 13.
  - tx_active=1 for exactly those N cycles.
  - On edge T+N: tx_bit returns to 1, tx_active drops, and frame_done=1 for exactly one cycle.
- Registered outputs only; there is no combinational path from any input to any output.
- Busy definition: state != IDLE. While busy:
  - trans_enable is ignored.
  - data_in changes have no effect on the frame in flight.
  - overrun is set to 1 and stays set until reset.
- trans_enable on the same edge as the last-bit transition (state PARITY, final cycle) counts as busy: it is ignored and sets overrun.
- trans_enable in the cycle where frame_done=1 (state already IDLE) is accepted normally. Minimum spacing between frames is therefore N+1 cycles.
- trans_enable held high for several cycles: only the first edge starts a frame; the remaining edges while busy set overrun.
- Bit-period counter counts 0..BIT_CYCLES-1 and wraps. The bit index counter uses ceil(log2(max(SYNC_W, DATA_W))+1) bits and never wraps mid-field.
- Reset mid-frame: all outputs immediately take their reset values; the partial frame is abandoned and frame_done does not pulse.

Decomposition:
- Shared package comm_pkg holds:
  - state enum (IDLE, SYNC, DATA, PARITY);
  - default SYNC_PAT constant, also used by the downstream sync detector;
  - localparam for frame length N.
- Sub-module frame_bit_timer:
  - parameter BIT_CYCLES; inputs sysclk, reset, run;
  - output bit_tick, one cycle at the end of each bit period;
  - the serializer FSM advances only on bit_tick.

Test Plan:
- Reset 5 cycles, then idle 20 cycles -> tx_bit=1, tx_active=0, frame_done=0, overrun=0 throughout.
- data_in=8'hA5, trans_enable pulse at edge T, defaults -> tx_bit over cycles T..T+12 = 1,0,1,0, 1,0,1,0,0,1,0,1, 0. tx_active=1 for 13 cycles; frame_done=1 only in cycle T+13.
- PARITY_ODD=1, data_in=8'h07 -> parity bit=0. PARITY_ODD=0, data_in=8'h07 -> parity bit=1.
- BIT_CYCLES=4, data_in=8'hFF -> each bit held 4 cycles, tx_active high 52 cycles, parity bit=0, frame_done at T+52.
- Second trans_enable at T+5, then another at T+12 -> both ignored, overrun=1 and stays 1. trans_enable at T+13 -> new frame accepted.
- reset asserted at T+6 mid-frame -> tx_bit=1 and tx_active=0 immediately, no frame_done. After release, a new trans_enable produces a full correct frame.
